hamming_scrub_ctrl: RTL and testbench
=====================================

// Module: hamming_scrub_ctrl
// PURPOSE
//  Sole owner of the 16x12 Hamming-SEC memory port. Arbitrates host byte read/write requests against a
//  periodic background scrubber. Encodes 8-bit data into 12-bit codewords on write. Decodes and corrects
//  single-bit errors on read, and writes the corrected codeword back. Sits between bus logic and the mem array.
// PARAMETERS
//  SCRUB_INTERVAL  256  clk cycles between scrub requests while scrub_en=1 (>=2)
//  MAX_DEFER       4    consecutive host grants allowed while a scrub is pending; the scrub then wins
// PORTS
//  clk           in   1   single clock, rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  req_valid     in   1   host request present
//  req_ready     out  1   controller accepts the request this cycle
//  req_we        in   1   1=write, 0=read
//  req_addr      in   4   word address
//  req_wdata     in   8   write data
//  resp_valid    out  1   one-cycle pulse: request completed
//  resp_rdata    out  8   corrected read data (0 for writes)
//  resp_corr     out  1   single-bit error corrected on this read
//  resp_uncorr   out  1   invalid syndrome (13..15) on this read; data returned uncorrected
//  scrub_en      in   1   enables the background scrub timer
//  err_count     out  8   saturating count of corrections (host and scrub)
//  mem_wr_en     out  1   to mem wr_en
//  mem_addr      out  4   to mem addr
//  mem_wdata     out  12  to mem data_in
//  mem_rdata     in   12  from mem data_out (combinational read of mem_addr)
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, FSM=IDLE, scrub_ptr=0, timer=0, defer_cnt=0, err_count=0.
//   A reset mid-operation drops the transaction with no memory write and no resp_valid.
//  Codeword: bit i-1 = Hamming position i (1..12). Parity at positions 1,2,4,8; data d0..d7 at 3,5,6,7,9,10,11,12.
//   Even parity. Syndrome = XOR of the positions of all set bits.
//  FSM states:
//   IDLE -> ACC on host accept or scrub grant.
//   ACC -> WB if read and syndrome in 1..12. Otherwise ACC -> IDLE.
//   WB -> IDLE.
//  req_ready = (state==IDLE) && !(scrub_pend && defer_cnt==MAX_DEFER). It is registered-free (combinational from state).
//  Accept edge N captures the request. ACC is cycle N+1: mem_addr=captured addr.
//   Write: mem_wr_en=1 with the encoded data.
//   Read: decode mem_rdata.
//  resp_valid, resp_rdata, resp_corr and resp_uncorr are registered at the end of ACC and visible in cycle N+2.
//   Write-back (WB), if needed, occurs in cycle N+2 with the corrected codeword.
//   Reads: host latency 2 cycles. Next accept no earlier than N+2 (no WB) or N+3 (WB).
//  Syndrome 0: clean. Syndrome 1..12: flip that bit; resp_corr=1; err_count++ (saturates at 255).
//   Syndrome 13..15: resp_uncorr=1; no write-back; no count.
//  Scrub timer:
//   Counts while scrub_en=1. At SCRUB_INTERVAL-1 it sets scrub_pend and wraps to 0.
//   scrub_en=0 clears the timer but not a pending scrub.
//   A new expiry while scrub_pend=1 is dropped.
//  Arbitration in IDLE: the host wins unless defer_cnt==MAX_DEFER.
//   defer_cnt increments on each host accept while scrub_pend=1. It clears when a scrub is granted.
//   With no host request, a pending scrub is granted immediately.
//  Scrub transaction: a read of scrub_ptr through ACC/WB with identical decode and write-back rules.
//   No resp_valid. Clears scrub_pend. scrub_ptr increments and wraps 15->0.
//  A host write to the address being scrubbed cannot collide: there is one transaction at a time.
// STRUCTURE
//  Package hamming_sec_pkg holds:
//   - constants: DATA_W=8, CODE_W=12, ADDR_W=4, PARITY_POS={1,2,4,8}
//   - the encode function and the syndrome function
//   - the state enum {IDLE, ACC, WB}
//  Sub-module hamming_sec_codec: combinational encode(8->12) and decode(12 -> data, syndrome, corr, uncorr).
//   Shared with other blocks.
// TESTING
//  1. Write 0xA5 to addr 3 -> mem_wdata=0xA27 with mem_wr_en in ACC; resp_valid 2 cycles after accept; resp_rdata=0.
//  2. Read addr 3 with mem word 0xA07 (pos6 flipped) -> resp_rdata=0xA5, resp_corr=1; WB writes 0xA27; err_count=1.
//  3. Read a word 0xAAE (syndrome 13) -> resp_uncorr=1, resp_corr=0, no mem_wr_en, err_count unchanged.
//  4. SCRUB_INTERVAL=8 with back-to-back host reads -> scrub granted after exactly MAX_DEFER=4 host accepts.
//     req_ready=0 that cycle. scrub_ptr 15 -> 0 wrap observed.
//  5. Pulse rst_n low during the WB cycle -> no further mem_wr_en; all outputs 0; err_count=0; IDLE afterwards.
//  6. scrub_en=0 -> no scrub transactions for 1000 cycles. Re-enable -> first scrub at cycle SCRUB_INTERVAL.

Source files
------------

// File: rtl/hamming_sec_pkg.sv
// Shared definitions for the 16x12 Hamming-SEC memory path: widths, codeword
// layout helpers and the controller state encoding.
package hamming_sec_pkg;

  localparam int DATA_W = 8;
  localparam int CODE_W = 12;
  localparam int ADDR_W = 4;
  localparam int SYN_W  = 4;
  localparam int PARITY_POS [4] = '{1, 2, 4, 8};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WB   = 2'd2
  } state_e;

  // Codeword bit i-1 holds Hamming position i; data sits at 3,5,6,7,9,10,11,12.
  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
    logic p1, p2, p4, p8;
    p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p4 = d[1] ^ d[2] ^ d[3] ^ d[7];
    p8 = d[4] ^ d[5] ^ d[6] ^ d[7];
    return {d[7], d[6], d[5], d[4], p8, d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [CODE_W-1:0] code);
    logic [SYN_W-1:0] syn;
    syn = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (code[i]) syn ^= SYN_W'(i + 1);
    end
    return syn;
  endfunction

  function automatic logic [DATA_W-1:0] hamming_extract(input logic [CODE_W-1:0] c);
    return {c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
  endfunction

endpackage

// File: rtl/hamming_sec_codec.sv
// Combinational Hamming-SEC encoder and single-error-correcting decoder.
// Invalid syndromes (beyond the codeword length) pass the word through untouched.
module hamming_sec_codec
  import hamming_sec_pkg::*;
(
  input  logic [DATA_W-1:0] enc_data_i,
  output logic [CODE_W-1:0] enc_code_o,
  input  logic [CODE_W-1:0] dec_code_i,
  output logic [CODE_W-1:0] dec_code_o,
  output logic [DATA_W-1:0] dec_data_o,
  output logic [SYN_W-1:0]  dec_syndrome_o,
  output logic              dec_corr_o,
  output logic              dec_uncorr_o
);

  logic [SYN_W-1:0] syn;

  assign enc_code_o     = hamming_encode(enc_data_i);
  assign syn            = hamming_syndrome(dec_code_i);
  assign dec_syndrome_o = syn;

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    dec_code_o   = dec_code_i;
    dec_corr_o   = 1'b0;
    dec_uncorr_o = 1'b0;
    if (syn > SYN_W'(CODE_W)) begin
      dec_uncorr_o = 1'b1;
    end else if (syn != '0) begin
      dec_corr_o = 1'b1;
      dec_code_o = dec_code_i ^ (CODE_W'(1) << (syn - 1'b1));
    end
  end

  assign dec_data_o = hamming_extract(dec_code_o);

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Single owner of the Hamming-SEC memory port: serves host byte reads/writes,
// corrects and writes back single-bit errors, and runs a periodic background scrub.
module hamming_scrub_ctrl
  import hamming_sec_pkg::*;
#(
  parameter int SCRUB_INTERVAL = 256,
  parameter int MAX_DEFER      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_corr,
  output logic              resp_uncorr,
  input  logic              scrub_en,
  output logic [7:0]        err_count,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CODE_W-1:0] mem_wdata,
  input  logic [CODE_W-1:0] mem_rdata
);

  localparam int TIMER_W = $clog2(SCRUB_INTERVAL);
  localparam int DEFER_W = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_scrub_q, is_scrub_d;
  logic [CODE_W-1:0]   wb_code_q, wb_code_d;
  logic [ADDR_W-1:0]   scrub_ptr_q, scrub_ptr_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                scrub_pend_q, scrub_pend_d;
  logic [DEFER_W-1:0]  defer_cnt_q, defer_cnt_d;
  logic [7:0]          err_count_q, err_count_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_corr_q, resp_corr_d;
  logic                resp_uncorr_q, resp_uncorr_d;

  logic [CODE_W-1:0]   enc_code, dec_code;
  logic [DATA_W-1:0]   dec_data;
  logic [SYN_W-1:0]    dec_syn;
  logic                dec_corr, dec_uncorr;
  logic                defer_full, host_accept, scrub_grant, timer_expire, need_wb;

  hamming_sec_codec u_codec (
    .enc_data_i     (wdata_q),
    .enc_code_o     (enc_code),
    .dec_code_i     (mem_rdata),
    .dec_code_o     (dec_code),
    .dec_data_o     (dec_data),
    .dec_syndrome_o (dec_syn),
    .dec_corr_o     (dec_corr),
    .dec_uncorr_o   (dec_uncorr)
  );

  // Gated by rst_n so the handshake reads 0 while the block is held in reset.
  assign defer_full  = scrub_pend_q && (defer_cnt_q == DEFER_W'(MAX_DEFER));
  assign req_ready   = rst_n && (state_q == IDLE) && !defer_full;
  assign host_accept = req_valid && req_ready;
  assign scrub_grant = (state_q == IDLE) && scrub_pend_q && !host_accept;
  assign need_wb     = !we_q && (dec_syn != '0) && (dec_syn <= SYN_W'(CODE_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values together.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (host_accept || scrub_grant) state_d = ACC;
      ACC:     state_d = need_wb ? WB : IDLE;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      ACC: begin
        mem_addr  = addr_q;
        mem_wr_en = we_q;
        mem_wdata = we_q ? enc_code : '0;
      end
      WB: begin
        mem_addr  = addr_q;
        mem_wr_en = 1'b1;
        mem_wdata = wb_code_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    is_scrub_d    = is_scrub_q;
    wb_code_d     = wb_code_q;
    scrub_ptr_d   = scrub_ptr_q;
    scrub_pend_d  = scrub_pend_q;
    defer_cnt_d   = defer_cnt_q;
    err_count_d   = err_count_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = '0;
    resp_corr_d   = 1'b0;
    resp_uncorr_d = 1'b0;
    timer_expire  = 1'b0;
    timer_d       = '0;

    if (scrub_en) begin
      if (timer_q == TIMER_W'(SCRUB_INTERVAL - 1)) begin
        timer_expire = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    if (host_accept) begin
      addr_d     = req_addr;
      we_d       = req_we;
      wdata_d    = req_wdata;
      is_scrub_d = 1'b0;
      if (scrub_pend_q) defer_cnt_d = defer_cnt_q + 1'b1;
    end else if (scrub_grant) begin
      addr_d       = scrub_ptr_q;
      we_d         = 1'b0;
      is_scrub_d   = 1'b1;
      scrub_ptr_d  = scrub_ptr_q + 1'b1;
      defer_cnt_d  = '0;
      scrub_pend_d = 1'b0;
    end

    // An expiry while a scrub is still pending is dropped rather than queued.
    if (timer_expire && !scrub_pend_q) scrub_pend_d = 1'b1;

    if (state_q == ACC) begin
      wb_code_d = dec_code;
      if (!we_q && dec_corr && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
      if (!is_scrub_q) begin
        resp_valid_d = 1'b1;
        if (!we_q) begin
          resp_rdata_d  = dec_data;
          resp_corr_d   = dec_corr;
          resp_uncorr_d = dec_uncorr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      is_scrub_q    <= 1'b0;
      wb_code_q     <= '0;
      scrub_ptr_q   <= '0;
      timer_q       <= '0;
      scrub_pend_q  <= 1'b0;
      defer_cnt_q   <= '0;
      err_count_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_corr_q   <= 1'b0;
      resp_uncorr_q <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      is_scrub_q    <= is_scrub_d;
      wb_code_q     <= wb_code_d;
      scrub_ptr_q   <= scrub_ptr_d;
      timer_q       <= timer_d;
      scrub_pend_q  <= scrub_pend_d;
      defer_cnt_q   <= defer_cnt_d;
      err_count_q   <= err_count_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_corr_q   <= resp_corr_d;
      resp_uncorr_q <= resp_uncorr_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_corr   = resp_corr_q;
  assign resp_uncorr = resp_uncorr_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl with a 16x12 memory model and a short scrub interval.
module tb_hamming_scrub_ctrl;
  import hamming_sec_pkg::*;

  localparam int SCRUB_INTERVAL = 8;
  localparam int MAX_DEFER      = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid, resp_corr, resp_uncorr;
  logic [7:0]  resp_rdata, err_count;
  logic        scrub_en;
  logic        mem_wr_en;
  logic [3:0]  mem_addr;
  logic [11:0] mem_wdata, mem_rdata;

  logic [11:0] mem [16];
  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [11:0] pre_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hamming_scrub_ctrl #(
    .SCRUB_INTERVAL (SCRUB_INTERVAL),
    .MAX_DEFER      (MAX_DEFER)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_corr   (resp_corr),
    .resp_uncorr (resp_uncorr),
    .scrub_en    (scrub_en),
    .err_count   (err_count),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic preload(input logic [3:0] a, input logic [11:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Drives one host request at a negedge and returns #1 after its accept edge.
  task automatic host_req(input logic we, input logic [3:0] a, input logic [7:0] d, input string tag);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL %s_ready got=%b exp=1", tag, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) preload(4'(i), 12'h000);
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_corr, resp_uncorr, err_count,
         mem_wr_en, mem_addr, mem_wdata} !== 37'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {req_ready, resp_valid, resp_rdata,
        resp_corr, resp_uncorr, err_count, mem_wr_en, mem_addr, mem_wdata});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, resp_valid, err_count, mem_wr_en} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      failures++; $display("FAIL reset_idle got=%h exp=%h", {req_ready, resp_valid, err_count, mem_wr_en},
        {1'b1, 1'b0, 8'd0, 1'b0});
    end
  endtask

  task automatic test_write();
    host_req(1'b1, 4'd3, 8'hA5, "wr");
    checks++;
    if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b1, 4'd3, 12'hA27}) begin
      failures++; $display("FAIL wr_acc got=%h exp=%h", {mem_wr_en, mem_addr, mem_wdata}, {1'b1, 4'd3, 12'hA27});
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++; $display("FAIL wr_early_resp got=%b exp=0", resp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({resp_valid, resp_rdata, resp_corr, resp_uncorr} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      failures++; $display("FAIL wr_resp got=%h exp=%h", {resp_valid, resp_rdata, resp_corr, resp_uncorr},
        {1'b1, 8'h00, 1'b0, 1'b0});
    end
    checks++;
    if (mem[3] !== 12'hA27) begin
      failures++; $display("FAIL wr_mem got=%h exp=a27", mem[3]);
    end
    @(posedge clk); #1;
    checks++;
    if ({resp_valid, mem_wr_en} !== 2'b00) begin
      failures++; $display("FAIL wr_pulse got=%b exp=00", {resp_valid, mem_wr_en});
    end
  endtask

  task automatic test_read_corr();
    preload(4'd3, 12'hA07);
    host_req(1'b0, 4'd3, 8'h00, "rdc");
    checks++;
    if ({mem_wr_en, mem_addr} !== {1'b0, 4'd3}) begin
      failures++; $display("FAIL rdc_acc got=%h exp=%h", {mem_wr_en, mem_addr}, {1'b0, 4'd3});
    end
    @(posedge clk); #1;
    checks++;
    if ({resp_valid, resp_rdata, resp_corr, resp_uncorr} !== {1'b1, 8'hA5, 1'b1, 1'b0}) begin
      failures++; $display("FAIL rdc_resp got=%h exp=%h", {resp_valid, resp_rdata, resp_corr, resp_uncorr},
        {1'b1, 8'hA5, 1'b1, 1'b0});
    end
    checks++;
    if (err_count !== 8'd1) begin
      failures++; $display("FAIL rdc_err_count got=%0d exp=1", err_count);
    end
    checks++;
    if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b1, 4'd3, 12'hA27}) begin
      failures++; $display("FAIL rdc_wb got=%h exp=%h", {mem_wr_en, mem_addr, mem_wdata}, {1'b1, 4'd3, 12'hA27});
    end
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL rdc_wb_ready got=%b exp=0", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({mem[3], req_ready, resp_valid} !== {12'hA27, 1'b1, 1'b0}) begin
      failures++; $display("FAIL rdc_after got=%h exp=%h", {mem[3], req_ready, resp_valid}, {12'hA27, 1'b1, 1'b0});
    end
  endtask

  task automatic test_read_uncorr();
    preload(4'd9, 12'hAAE);
    host_req(1'b0, 4'd9, 8'h00, "rdu");
    checks++;
    if (mem_wr_en !== 1'b0) begin
      failures++; $display("FAIL rdu_acc_wr got=%b exp=0", mem_wr_en);
    end
    @(posedge clk); #1;
    checks++;
    if ({resp_valid, resp_rdata, resp_corr, resp_uncorr} !== {1'b1, 8'hA5, 1'b0, 1'b1}) begin
      failures++; $display("FAIL rdu_resp got=%h exp=%h", {resp_valid, resp_rdata, resp_corr, resp_uncorr},
        {1'b1, 8'hA5, 1'b0, 1'b1});
    end
    checks++;
    if ({err_count, mem_wr_en, req_ready} !== {8'd1, 1'b0, 1'b1}) begin
      failures++; $display("FAIL rdu_no_wb got=%h exp=%h", {err_count, mem_wr_en, req_ready}, {8'd1, 1'b0, 1'b1});
    end
    checks++;
    if (mem[9] !== 12'hAAE) begin
      failures++; $display("FAIL rdu_mem got=%h exp=aae", mem[9]);
    end
  endtask

  // Back-to-back host reads against a running scrub timer: every scrub must be
  // granted after exactly MAX_DEFER pending-time host accepts, walking addresses 0..15,0.
  task automatic test_back_to_back();
    int         accepts  = 0;
    int         scrubs   = 0;
    bit         acc_next = 1'b0;
    logic [3:0] exp_ptr  = 4'd0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5; scrub_en = 1'b1;
    for (int cyc = 0; cyc < 1000 && scrubs < 17; cyc++) begin
      @(negedge clk);
      if (acc_next) begin
        acc_next = 1'b0;
        checks++;
        if (mem_addr !== exp_ptr) begin
          failures++; $display("FAIL b2b_scrub_addr got=%0d exp=%0d", mem_addr, exp_ptr);
        end
        exp_ptr++;
        scrubs++;
      end else if (dut.state_q == IDLE && dut.scrub_pend_q) begin
        if (req_ready) begin
          accepts++;
        end else begin
          checks++;
          if (accepts != MAX_DEFER) begin
            failures++; $display("FAIL b2b_defer got=%0d exp=%0d", accepts, MAX_DEFER);
          end
          accepts  = 0;
          acc_next = 1'b1;
        end
      end
    end
    checks++;
    if (scrubs != 17) begin
      failures++; $display("FAIL b2b_scrub_total got=%0d exp=17", scrubs);
    end
    req_valid = 1'b0; scrub_en = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_reset_in_wb();
    int late_wr = 0;
    preload(4'd7, 12'hA07);
    host_req(1'b0, 4'd7, 8'h00, "rst");
    @(posedge clk); #1;
    checks++;
    if (mem_wr_en !== 1'b1) begin
      failures++; $display("FAIL rst_wb_entry got=%b exp=1", mem_wr_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_corr, resp_uncorr, err_count,
         mem_wr_en, mem_addr, mem_wdata} !== 37'd0) begin
      failures++; $display("FAIL rst_outputs got=%h exp=0", {req_ready, resp_valid, resp_rdata,
        resp_corr, resp_uncorr, err_count, mem_wr_en, mem_addr, mem_wdata});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem[7] !== 12'hA07) begin
      failures++; $display("FAIL rst_no_write got=%h exp=a07", mem[7]);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, resp_valid, err_count} !== {1'b1, 1'b0, 8'd0}) begin
      failures++; $display("FAIL rst_idle got=%h exp=%h", {req_ready, resp_valid, err_count}, {1'b1, 1'b0, 8'd0});
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_wr_en) late_wr++;
    end
    checks++;
    if (late_wr != 0) begin
      failures++; $display("FAIL rst_late_write got=%0d exp=0", late_wr);
    end
  endtask

  // With no host traffic req_ready only drops while a scrub owns the port.
  // Timer reaches SCRUB_INTERVAL-1 after SCRUB_INTERVAL-1 edges, pend rises on
  // edge SCRUB_INTERVAL, and the grant edge that enters ACC is SCRUB_INTERVAL+1.
  task automatic test_scrub_enable();
    int busy  = 0;
    int first = 0;
    scrub_en = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (!req_ready) busy++;
    end
    checks++;
    if (busy != 0) begin
      failures++; $display("FAIL en_off_busy got=%0d exp=0", busy);
    end
    @(negedge clk); scrub_en = 1'b1;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      @(posedge clk); #1;
      if (!req_ready) first = k;
    end
    checks++;
    if (first != SCRUB_INTERVAL + 1) begin
      failures++; $display("FAIL en_first_scrub got=%0d exp=%0d", first, SCRUB_INTERVAL + 1);
    end
    scrub_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    scrub_en = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset();
    test_write();
    test_read_corr();
    test_read_uncorr();
    test_back_to_back();
    test_reset_in_wb();
    test_scrub_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
